axis_arb_mux: RTL and testbench

AXIS_ARB_MUX -- requirements
Module: axis_arb_mux

---
 rtl/axis_arb_mux.sv | 131 +++++++++++++
 tb/tb_axis_arb_mux.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_arb_mux.sv
// Packet-level round-robin AXI-Stream style mux: one arbitration bubble per packet,
// grant held until the last beat, and a two-entry (output + skid) register stage.
module axis_arb_mux #(
    parameter int  DATA_WIDTH = 64,
    parameter int  PORTS      = 4,
    localparam int SW         = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            i_valid,
    output logic [PORTS-1:0]            i_ready,
    input  logic [PORTS*DATA_WIDTH-1:0] i_data,
    input  logic [PORTS-1:0]            i_last,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_last,
    output logic [SW-1:0]               o_src
);

    localparam int unsigned NP = PORTS;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q;
    logic [SW-1:0]         g_q;
    logic [SW-1:0]         p_q;
    logic [SW-1:0]         grant_d;
    logic [SW-1:0]         cand;
    logic                  found;

    logic                  ov_q;
    logic [DATA_WIDTH-1:0] od_q;
    logic                  ol_q;
    logic [SW-1:0]         os_q;
    logic                  sv_q;
    logic [DATA_WIDTH-1:0] sd_q;
    logic                  sl_q;
    logic [SW-1:0]         ss_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;

    // Round-robin search starting just after the last winner.
    always_comb begin
        grant_d = g_q;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NP; k++) begin
            cand = SW'((32'(p_q) + k) % NP);
            if (!found && i_valid[cand]) begin
                found   = 1'b1;
                grant_d = cand;
            end
        end
    end

    always_comb begin
        i_ready = '0;
        if (state_q == LOCKED && !sv_q) begin
            i_ready[g_q] = 1'b1;
        end
    end

    assign accept    = i_ready[g_q] & i_valid[g_q];
    assign beat_data = i_data[int'(g_q) * DATA_WIDTH +: DATA_WIDTH];
    assign beat_last = i_last[g_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= SW'(PORTS - 1);
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            os_q    <= '0;
            sv_q    <= 1'b0;
            sd_q    <= '0;
            sl_q    <= 1'b0;
            ss_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|i_valid) begin
                        g_q     <= grant_d;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && beat_last) begin
                        p_q     <= g_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // accept implies the skid stage is empty, so the two branches never collide.
            if (accept) begin
                if (!ov_q || o_ready) begin
                    ov_q <= 1'b1;
                    od_q <= beat_data;
                    ol_q <= beat_last;
                    os_q <= g_q;
                end else begin
                    sv_q <= 1'b1;
                    sd_q <= beat_data;
                    sl_q <= beat_last;
                    ss_q <= g_q;
                end
            end else if (ov_q && o_ready) begin
                if (sv_q) begin
                    od_q <= sd_q;
                    ol_q <= sl_q;
                    os_q <= ss_q;
                    sv_q <= 1'b0;
                end else begin
                    ov_q <= 1'b0;
                end
            end
        end
    end

    assign o_valid = ov_q;
    assign o_data  = od_q;
    assign o_last  = ol_q;
    assign o_src   = os_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed scoreboard bench for axis_arb_mux: expected beats are queued by the
// stimulus thread and popped by an independent output monitor.
module tb_axis_arb_mux;

    localparam int DW = 64;
    localparam int NP = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NP-1:0]     i_valid = '0;
    logic [NP-1:0]     i_ready;
    logic [NP*DW-1:0]  i_data  = '0;
    logic [NP-1:0]     i_last  = '0;
    logic              o_valid;
    logic              o_ready = 1'b1;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic [1:0]        o_src;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    s;
    } beat_t;

    beat_t       sb[$];
    int unsigned out_cyc[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          acc3 = 0;
    logic        stall_q = 1'b0;
    beat_t       held;

    axis_arb_mux #(.DATA_WIDTH(DW), .PORTS(NP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_src   (o_src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop, hold-stability and single-grant checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", o_valid, 1'b1);
                chk("hold_beat", {o_data, o_last, o_src}, held);
            end
            chk("onehot_ready", $countones(i_ready) <= 1, 1'b1);
            if (i_valid[3] && i_ready[3]) acc3++;
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %0h src %0d, expected none", o_data, o_src);
                end else begin
                    chk("out_beat", {o_data, o_last, o_src}, sb.pop_front());
                    out_cyc.push_back(cyc);
                end
            end
            stall_q = o_valid && !o_ready;
            held    = {o_data, o_last, o_src};
        end
    end

    task automatic expect_pkt(input int p, input int n, input logic [DW-1:0] base);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.d = base + 64'(b);
            e.l = (b == n - 1);
            e.s = 2'(p);
            sb.push_back(e);
        end
    endtask

    task automatic send(input int p, input int n, input logic [DW-1:0] base);
        int   guard;
        logic took;
        for (int b = 0; b < n; b++) begin
            guard = 0;
            took  = 1'b0;
            i_valid[p]          = 1'b1;
            i_data[p*DW +: DW]  = base + 64'(b);
            i_last[p]           = (b == n - 1);
            while (!took) begin
                took = i_ready[p];
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    i_valid[p] = 1'b0;
                    i_last[p]  = 1'b0;
                    return;
                end
                guard++;
                if (guard > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout port %0d beat %0d: got no accept, expected accept within 200 cycles", p, b);
                    i_valid[p] = 1'b0;
                    return;
                end
            end
        end
        i_valid[p] = 1'b0;
        i_last[p]  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 || o_valid) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d pending beats, expected 0", sb.size());
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_valid = '0;
        i_last  = '0;
        o_ready = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_i_ready", i_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        out_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1);
    end

    initial begin
        // Single 3-beat packet on port 2, sink always ready.
        do_reset();
        expect_pkt(2, 3, 64'hA0);
        fork
            send(2, 3, 64'hA0);
            begin
                #1;
                chk("s1_bubble_ready", i_ready, 4'b0000);
                @(negedge clk);
                chk("s1_grant_ready", i_ready, 4'b0100);
                chk("s1_no_out_yet", o_valid, 1'b0);
                @(negedge clk);
                chk("s1_latency", o_valid, 1'b1);
                @(negedge clk);
                @(negedge clk);
                chk("s1_post_bubble", i_ready, 4'b0000);
            end
        join
        wait_drain();
        chk("s1_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) chk("s1_back_to_back", out_cyc[2] - out_cyc[0], 2);

        // Four simultaneous single-beat packets: served 0,1,2,3 with one bubble each.
        do_reset();
        for (int p = 0; p < NP; p++) expect_pkt(p, 1, 64'h100 * p + 64'hB0);
        fork
            send(0, 1, 64'hB0);
            send(1, 1, 64'h1B0);
            send(2, 1, 64'h2B0);
            send(3, 1, 64'h3B0);
        join
        wait_drain();
        chk("s2_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4) begin
            chk("s2_gap01", out_cyc[1] - out_cyc[0], 2);
            chk("s2_gap12", out_cyc[2] - out_cyc[1], 2);
            chk("s2_gap23", out_cyc[3] - out_cyc[2], 2);
        end

        // Port 0 requests while port 1 is mid-packet: port 1 must finish first.
        do_reset();
        expect_pkt(1, 4, 64'hC10);
        expect_pkt(0, 2, 64'hC00);
        fork
            send(1, 4, 64'hC10);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(0, 2, 64'hC00);
            end
        join
        wait_drain();

        // Sink stalls 4 cycles during a port 3 stream: two beats buffered.
        do_reset();
        acc3 = 0;
        expect_pkt(3, 6, 64'hD0);
        fork
            send(3, 6, 64'hD0);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                o_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("s4_held_beats", acc3, 2);
                chk("s4_ready3_low", i_ready[3], 1'b0);
                chk("s4_out_valid", o_valid, 1'b1);
                chk("s4_out_data", o_data, 64'hD0);
                o_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-packet with both stages full, then priority restarts at port 0.
        do_reset();
        expect_pkt(0, 1, 64'hE0);
        send(0, 1, 64'hE0);
        wait_drain();
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        fork
            send(1, 5, 64'hE10);
        join_none
        repeat (3) @(posedge clk);
        #2;
        chk("s5_pre_valid", o_valid, 1'b1);
        chk("s5_pre_skid_full", i_ready, 4'b0000);
        chk("s5_pre_data", o_data, 64'hE10);
        rst_n = 1'b0;
        #1;
        chk("s5_async_valid", o_valid, 1'b0);
        chk("s5_async_ready", i_ready, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        o_ready = 1'b1;
        rst_n   = 1'b1;
        expect_pkt(0, 1, 64'hE20);
        expect_pkt(1, 1, 64'hE30);
        fork
            send(1, 1, 64'hE30);
            send(0, 1, 64'hE20);
        join
        wait_drain();

        chk("sb_final_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
